// File: rtl/execute_mem_issue_if.sv
// rtl/execute_mem_issue_if.sv - dispatch, writeback, issue and flush bundle for the memory issue queue
interface execute_mem_issue_if;
   logic        bco_valid;
   logic        i_valid;
   logic        o_ready;
   logic [3:0]  i_src0_rob;
   logic [3:0]  i_src1_rob;
   logic        i_src0_rdy;
   logic        i_src1_rdy;
   logic [31:0] i_src0_value;
   logic [31:0] i_src1_value;
   logic [3:0]  i_dst_rob;
   logic [25:0] i_imm;
   logic [7:0]  i_fid;
   logic [4:0]  i_mem_cmd;
   logic        i_wb_valid;
   logic [3:0]  i_wb_rob;
   logic [31:0] i_wb_value;
   logic        i_issue_ready;
   logic        o_issue_valid;
   logic [31:0] o_src0_value;
   logic [31:0] o_src1_value;
   logic [3:0]  o_dst_rob;
   logic [25:0] o_imm;
   logic [7:0]  o_fid;
   logic [4:0]  o_mem_cmd;

   modport master (
      output bco_valid, i_valid, i_src0_rob, i_src1_rob, i_src0_rdy, i_src1_rdy,
             i_src0_value, i_src1_value, i_dst_rob, i_imm, i_fid, i_mem_cmd,
             i_wb_valid, i_wb_rob, i_wb_value, i_issue_ready,
      input  o_ready, o_issue_valid, o_src0_value, o_src1_value, o_dst_rob,
             o_imm, o_fid, o_mem_cmd
   );

   modport slave (
      input  bco_valid, i_valid, i_src0_rob, i_src1_rob, i_src0_rdy, i_src1_rdy,
             i_src0_value, i_src1_value, i_dst_rob, i_imm, i_fid, i_mem_cmd,
             i_wb_valid, i_wb_rob, i_wb_value, i_issue_ready,
      output o_ready, o_issue_valid, o_src0_value, o_src1_value, o_dst_rob,
             o_imm, o_fid, o_mem_cmd
   );
endinterface

// File: rtl/execute_mem_issue.sv
// rtl/execute_mem_issue.sv - in-order memory-pipe issue queue with writeback wakeup and flush
// Optional same-cycle empty-queue bypass: EXECUTE_MEM_ISSUE_BYPASS_EN.
module execute_mem_issue #(
   parameter int DEPTH = 4
) (
   input logic                clk,
   input logic                resetn,
   execute_mem_issue_if.slave mif
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   logic [DEPTH-1:0] vld;
   logic [DEPTH-1:0] s0_rdy;
   logic [DEPTH-1:0] s1_rdy;
   logic [3:0]       s0_tag [DEPTH];
   logic [3:0]       s1_tag [DEPTH];
   logic [31:0]      s0_val [DEPTH];
   logic [31:0]      s1_val [DEPTH];
   logic [3:0]       dst    [DEPTH];
   logic [25:0]      imm    [DEPTH];
   logic [7:0]       fid    [DEPTH];
   logic [4:0]       cmd    [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW:0]   count;

   logic        enq_s0_rdy;
   logic        enq_s1_rdy;
   logic [31:0] enq_s0_val;
   logic [31:0] enq_s1_val;
   logic        q_issue;
   logic        byp;
   logic        enq;
   logic        pop;

   // A writeback landing in the dispatch cycle is folded into the incoming entry.
   always_comb begin
      enq_s0_rdy = mif.i_src0_rdy | (mif.i_wb_valid & (mif.i_wb_rob == mif.i_src0_rob));
      enq_s1_rdy = mif.i_src1_rdy | (mif.i_wb_valid & (mif.i_wb_rob == mif.i_src1_rob));
      enq_s0_val = mif.i_src0_rdy ? mif.i_src0_value : mif.i_wb_value;
      enq_s1_val = mif.i_src1_rdy ? mif.i_src1_value : mif.i_wb_value;
   end

   assign q_issue = vld[head] & s0_rdy[head] & s1_rdy[head] & ~mif.bco_valid;

`ifdef EXECUTE_MEM_ISSUE_BYPASS_EN
   assign byp = (count == '0) & mif.i_valid & enq_s0_rdy & enq_s1_rdy & ~mif.bco_valid;
`else
   assign byp = 1'b0;
`endif

   assign mif.o_ready       = resetn & (count != FULL);
   assign enq               = mif.i_valid & mif.o_ready & ~mif.bco_valid & ~(byp & mif.i_issue_ready);
   assign pop               = q_issue & mif.i_issue_ready;
   assign mif.o_issue_valid = q_issue | byp;

   assign mif.o_src0_value = byp ? enq_s0_val    : s0_val[head];
   assign mif.o_src1_value = byp ? enq_s1_val    : s1_val[head];
   assign mif.o_dst_rob    = byp ? mif.i_dst_rob : dst[head];
   assign mif.o_imm        = byp ? mif.i_imm     : imm[head];
   assign mif.o_fid        = byp ? mif.i_fid     : fid[head];
   assign mif.o_mem_cmd    = byp ? mif.i_mem_cmd : cmd[head];

   always_ff @(posedge clk) begin
      if (!resetn || mif.bco_valid) begin
         vld   <= '0;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (pop) begin
            vld[head] <= 1'b0;
            head      <= head + 1'b1;
         end
         if (enq) begin
            vld[tail] <= 1'b1;
            tail      <= tail + 1'b1;
         end
         case ({enq, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Payload and ready bits are qualified by vld, so they carry no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (vld[i] && !s0_rdy[i] && mif.i_wb_valid && s0_tag[i] == mif.i_wb_rob) begin
            s0_rdy[i] <= 1'b1;
            s0_val[i] <= mif.i_wb_value;
         end
         if (vld[i] && !s1_rdy[i] && mif.i_wb_valid && s1_tag[i] == mif.i_wb_rob) begin
            s1_rdy[i] <= 1'b1;
            s1_val[i] <= mif.i_wb_value;
         end
      end
      if (enq) begin
         s0_rdy[tail] <= enq_s0_rdy;
         s1_rdy[tail] <= enq_s1_rdy;
         s0_tag[tail] <= mif.i_src0_rob;
         s1_tag[tail] <= mif.i_src1_rob;
         s0_val[tail] <= enq_s0_val;
         s1_val[tail] <= enq_s1_val;
         dst[tail]    <= mif.i_dst_rob;
         imm[tail]    <= mif.i_imm;
         fid[tail]    <= mif.i_fid;
         cmd[tail]    <= mif.i_mem_cmd;
      end
   end
endmodule

// File: tb/tb_execute_mem_issue.sv
// tb/tb_execute_mem_issue.sv - directed self-checking bench for execute_mem_issue
module tb_execute_mem_issue;
   logic clk;
   logic resetn;
   int   n_vec;
   int   n_err;
   logic [31:0] exp_q [$];

   execute_mem_issue_if mif ();

   execute_mem_issue #(.DEPTH(4)) dut (
      .clk    (clk),
      .resetn (resetn),
      .mif    (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_op(input logic rdy0, input logic [3:0] tag0, input logic [31:0] val0,
                           input logic rdy1, input logic [3:0] tag1, input logic [31:0] val1,
                           input logic [4:0] c);
      mif.i_valid      = 1'b1;
      mif.i_src0_rdy   = rdy0;
      mif.i_src0_rob   = tag0;
      mif.i_src0_value = val0;
      mif.i_src1_rdy   = rdy1;
      mif.i_src1_rob   = tag1;
      mif.i_src1_value = val1;
      mif.i_mem_cmd    = c;
      mif.i_dst_rob    = 4'd1;
      mif.i_imm        = 26'h12345;
      mif.i_fid        = 8'h5a;
      #1;
   endtask

   task automatic idle();
      mif.i_valid    = 1'b0;
      mif.i_wb_valid = 1'b0;
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      resetn = 1'b0;
      mif.bco_valid = 1'b0;
      mif.i_valid = 1'b0;
      mif.i_src0_rob = '0;
      mif.i_src1_rob = '0;
      mif.i_src0_rdy = 1'b0;
      mif.i_src1_rdy = 1'b0;
      mif.i_src0_value = '0;
      mif.i_src1_value = '0;
      mif.i_dst_rob = '0;
      mif.i_imm = '0;
      mif.i_fid = '0;
      mif.i_mem_cmd = '0;
      mif.i_wb_valid = 1'b0;
      mif.i_wb_rob = '0;
      mif.i_wb_value = '0;
      mif.i_issue_ready = 1'b0;

      step();
      step();
      check("rst_ready", 32'(mif.o_ready), 32'd0);
      check("rst_issue", 32'(mif.o_issue_valid), 32'd0);
      resetn = 1'b1;
      step();
      check("post_rst_ready", 32'(mif.o_ready), 32'd1);
      check("post_rst_issue", 32'(mif.o_issue_valid), 32'd0);

      // basic enqueue and issue
      mif.i_issue_ready = 1'b1;
      drive_op(1'b1, 4'd0, 32'h11, 1'b1, 4'd0, 32'h22, 5'd5);
`ifdef EXECUTE_MEM_ISSUE_BYPASS_EN
      check("byp_issue", 32'(mif.o_issue_valid), 32'd1);
      check("byp_src0", mif.o_src0_value, 32'h11);
      check("byp_cmd", 32'(mif.o_mem_cmd), 32'd5);
      step();
      idle();
`else
      check("t1_no_issue_c0", 32'(mif.o_issue_valid), 32'd0);
      step();
      idle();
      check("t1_issue", 32'(mif.o_issue_valid), 32'd1);
      check("t1_src0", mif.o_src0_value, 32'h11);
      check("t1_src1", mif.o_src1_value, 32'h22);
      check("t1_cmd", 32'(mif.o_mem_cmd), 32'd5);
      step();
`endif
      check("t1_empty", 32'(mif.o_issue_valid), 32'd0);

      // wakeup on src1 tag 7
      drive_op(1'b1, 4'd0, 32'h33, 1'b0, 4'd7, 32'h0, 5'd6);
      step();
      idle();
      check("t2_wait0", 32'(mif.o_issue_valid), 32'd0);
      step();
      check("t2_wait1", 32'(mif.o_issue_valid), 32'd0);
      step();
      mif.i_wb_valid = 1'b1;
      mif.i_wb_rob   = 4'd7;
      mif.i_wb_value = 32'hDEADBEEF;
      #1;
      check("t2_wait2", 32'(mif.o_issue_valid), 32'd0);
      step();
      idle();
      check("t2_issue", 32'(mif.o_issue_valid), 32'd1);
      check("t2_src1", mif.o_src1_value, 32'hDEADBEEF);
      check("t2_src0", mif.o_src0_value, 32'h33);
      step();
      check("t2_empty", 32'(mif.o_issue_valid), 32'd0);

      // in-order: A waits on tag 3, B ready behind it
      drive_op(1'b0, 4'd3, 32'h0, 1'b1, 4'd0, 32'hA1, 5'd1);
      step();
      drive_op(1'b1, 4'd0, 32'hB0, 1'b1, 4'd0, 32'hB1, 5'd2);
      step();
      idle();
      check("t3_block0", 32'(mif.o_issue_valid), 32'd0);
      step();
      check("t3_block1", 32'(mif.o_issue_valid), 32'd0);
      mif.i_wb_valid = 1'b1;
      mif.i_wb_rob   = 4'd3;
      mif.i_wb_value = 32'h333;
      step();
      idle();
      check("t3_a_issue", 32'(mif.o_issue_valid), 32'd1);
      check("t3_a_cmd", 32'(mif.o_mem_cmd), 32'd1);
      check("t3_a_src0", mif.o_src0_value, 32'h333);
      step();
      check("t3_b_issue", 32'(mif.o_issue_valid), 32'd1);
      check("t3_b_cmd", 32'(mif.o_mem_cmd), 32'd2);
      step();
      check("t3_empty", 32'(mif.o_issue_valid), 32'd0);

      // fill to full, pop one, then stream 10 ops through with wrap
      mif.i_issue_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         check("t4_ready_pre", 32'(mif.o_ready), 32'd1);
         drive_op(1'b1, 4'd0, 32'hA0 + 32'(k), 1'b1, 4'd0, 32'h0, 5'd3);
         step();
      end
      idle();
      check("t4_full", 32'(mif.o_ready), 32'd0);
      check("t4_head", mif.o_src0_value, 32'hA0);
      mif.i_issue_ready = 1'b1;
      step();
      mif.i_issue_ready = 1'b0;
      #1;
      check("t4_ready_after_pop", 32'(mif.o_ready), 32'd1);
      check("t4_head2", mif.o_src0_value, 32'hA1);
      exp_q = '{32'hA1, 32'hA2, 32'hA3};
      mif.i_issue_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         drive_op(1'b1, 4'd0, 32'h100 + 32'(k), 1'b1, 4'd0, 32'h0, 5'd4);
         check("t4_wrap_valid", 32'(mif.o_issue_valid), 32'd1);
         check("t4_wrap_src0", mif.o_src0_value, exp_q[0]);
         step();
         void'(exp_q.pop_front());
         exp_q.push_back(32'h100 + 32'(k));
      end
      mif.i_issue_ready = 1'b0;
      idle();
      check("t4_wrap_head", mif.o_src0_value, exp_q[0]);

      // flush with 3 entries held, racing enqueue and issue
      mif.bco_valid     = 1'b1;
      mif.i_issue_ready = 1'b1;
      drive_op(1'b1, 4'd0, 32'hF0, 1'b1, 4'd0, 32'hF1, 5'd7);
      check("t5_flush_issue", 32'(mif.o_issue_valid), 32'd0);
      step();
      mif.bco_valid = 1'b0;
      idle();
      check("t5_ready", 32'(mif.o_ready), 32'd1);
      check("t5_issue", 32'(mif.o_issue_valid), 32'd0);
      step();
      check("t5_issue2", 32'(mif.o_issue_valid), 32'd0);

      // reset while full; stale entries must never issue
      mif.i_issue_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive_op(1'b1, 4'd0, 32'hC0 + 32'(k), 1'b1, 4'd0, 32'h0, 5'd8);
         step();
      end
      idle();
      check("t6_full", 32'(mif.o_ready), 32'd0);
      resetn = 1'b0;
      #1;
      check("t6_rst_ready", 32'(mif.o_ready), 32'd0);
      step();
      check("t6_rst_issue", 32'(mif.o_issue_valid), 32'd0);
      resetn = 1'b1;
      step();
      check("t6_post_ready", 32'(mif.o_ready), 32'd1);
      check("t6_post_issue", 32'(mif.o_issue_valid), 32'd0);
      mif.i_issue_ready = 1'b1;
      step();
      check("t6_stale", 32'(mif.o_issue_valid), 32'd0);

      // same-cycle writeback match at dispatch
      mif.i_issue_ready = 1'b0;
      mif.i_wb_valid = 1'b1;
      mif.i_wb_rob   = 4'd9;
      mif.i_wb_value = 32'h99;
      drive_op(1'b1, 4'd0, 32'hE0, 1'b0, 4'd9, 32'h0, 5'd9);
      step();
      idle();
      check("t7_issue", 32'(mif.o_issue_valid), 32'd1);
      check("t7_src0", mif.o_src0_value, 32'hE0);
      check("t7_src1", mif.o_src1_value, 32'h99);
      mif.i_issue_ready = 1'b1;
      step();
      check("t7_empty", 32'(mif.o_issue_valid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/execute_mem_issue.md
# execute_mem_issue

In-order issue queue and scheduler for the memory execution pipe. Accepts memory micro-ops from dispatch, holds them until both source operands are available (captured from the writeback broadcast), and issues the oldest entry into the memory-pipe input register stage when it accepts. Flushes all pending micro-ops on a branch-correction (`bco_valid`) event.

## Interface

- `DEPTH`, default 4: number of queue entries. Power of two, ≥2.
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `bco_valid`  in  1  branch-correction flush.
- `i_valid`  in  1  dispatch micro-op valid.
- `o_ready`  out  1  queue can accept (`~full`; 0 while `resetn`=0).
- `i_src0_rob`, `i_src1_rob`  in  4 each  ROB tags of the source producers.
- `i_src0_rdy`, `i_src1_rdy`  in  1 each  source value already valid at dispatch.
- `i_src0_value`, `i_src1_value`  in  32 each  source values, meaningful when the matching `rdy` is 1.
- `i_dst_rob`  in  4  destination ROB tag.
- `i_imm`  in  26  immediate.
- `i_fid`  in  8  fetch id.
- `i_mem_cmd`  in  5  memory command.
- `i_wb_valid`  in  1  writeback broadcast valid.
- `i_wb_rob`  in  4  writeback ROB tag.
- `i_wb_value`  in  32  writeback value.
- `i_issue_ready`  in  1  memory pipe accepts this cycle.
- `o_issue_valid`  out  1  head entry issuable.
- `o_src0_value`, `o_src1_value`, `o_dst_rob`, `o_imm`, `o_fid`, `o_mem_cmd`  out  32/32/4/26/8/5  head entry payload.

## Operation

- Circular buffer with `DEPTH` entries, head/tail pointers of `log2(DEPTH)` bits that wrap modulo `DEPTH`, and a count of `log2(DEPTH)+1` bits.
- Each entry holds: valid, per-source ready bit, tag, value, and the `dst_rob`, `imm`, `fid`, and `mem_cmd` fields.
- Enqueue occurs when `i_valid & o_ready & ~bco_valid`. The payload is written at the tail.
  - A source whose `rdy` is 0 but whose tag matches `i_wb_rob` while `i_wb_valid` is set in the same cycle is written as ready with `i_wb_value`.
- Wakeup: every valid entry whose source is not ready and whose tag equals `i_wb_rob` while `i_wb_valid` is set captures `i_wb_value` and sets that source's ready bit at the clock edge.
- Issue is strictly in order; only the head may issue.
  - `o_issue_valid` = head valid & src0 ready & src1 ready & `~bco_valid`.
  - Handshake: issue fires when `o_issue_valid & i_issue_ready`. The head is popped at that edge.
- Payload outputs are combinational from the head entry and are don't-care when `o_issue_valid` is 0.
- `o_ready` = `count != DEPTH`. It does not depend on `i_issue_ready`, so there is no combinational path from the memory pipe to dispatch.
- Enqueue and issue in the same cycle: count is unchanged and both pointers advance.
- Flush: while `bco_valid` is 1, enqueue and issue are suppressed. At the edge, all valid bits, pointers, and count clear. A flush takes priority over a simultaneous enqueue, issue, or wakeup.
- Reset (`resetn`=0 at an edge, including mid-operation) clears valid bits, pointers, and count. Entry payloads are not reset.

## Timing

- Reset values: `o_issue_valid`=0, `o_ready`=0 during reset and 1 from the first cycle after reset deasserts. Payload outputs are undefined.
- Enqueue → issue latency is 1 cycle minimum: an entry with both sources ready at dispatch presents `o_issue_valid`=1 the cycle after acceptance.
- Wakeup → issue latency is 1 cycle: the value captured at edge N is issuable in cycle N+1.
- Full queue: `o_ready`=0. A pop in cycle N makes `o_ready`=1 in cycle N+1.
- Flush at edge N: `o_ready`=1 and `o_issue_valid`=0 in cycle N+1.

## Configuration

- `EXECUTE_MEM_ISSUE_BYPASS_EN` defined: same-cycle bypass is enabled. It applies when all of the following hold:
  - the queue is empty (count=0),
  - `i_valid`=1,
  - both sources are ready at dispatch (including via the same-cycle wakeup match),
  - `bco_valid`=0.

  In that case `o_issue_valid`=1 and the payload outputs are driven directly from the inputs. If `i_issue_ready`=1, the micro-op is consumed and not written. Otherwise it is enqueued normally.
- Macro not defined: no bypass path, and the minimum latency is 1 cycle.

## Test plan

- Reset, then enqueue op (src0=0x11, src1=0x22, both ready, `mem_cmd`=5) with `i_issue_ready`=1 → next cycle `o_issue_valid`=1, `o_src0_value`=0x11, `o_mem_cmd`=5; following cycle queue is empty. With bypass defined: issued in the same cycle.
- Enqueue op with src1 tag 7 not ready; 3 cycles later `wb_valid`, `wb_rob`=7, value 0xDEADBEEF → `o_issue_valid` rises the cycle after the wakeup with `o_src1_value`=0xDEADBEEF.
- Enqueue A (waiting on tag 3), then B (ready) → B is not issued before A. Wake tag 3 → A issues, then B the next cycle.
- Hold `i_issue_ready`=0 and enqueue 4 ops → `o_ready`=0 after the 4th. One issue → `o_ready`=1 the next cycle. Pointer wraps correctly over 10 further ops.
- Queue holds 3 ops; assert `bco_valid` together with `i_valid` and `i_issue_ready` → nothing issues or enqueues. Next cycle: count 0, `o_issue_valid`=0, `o_ready`=1.
- Drive `resetn`=0 mid-stream with a full queue → next cycle `o_issue_valid`=0. After release, `o_ready`=1 and old entries never issue.
